instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: two-cycle FETCH/EXEC instruction sequencer in front of a
// synchronous instruction ROM. Holds the program counter, presents the
// current instruction to the control decoder for one EXEC cycle, and
// resolves halt / taken-branch / sequential next-PC at the end of EXEC.
module instr_fetch #(
    parameter int PW        = 10,
    parameter int IW        = 9,
    parameter int mcodebits = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Branch,
    input  logic                 Taken,
    input  logic [PW-1:0]        BrTarget,
    output logic [PW-1:0]        rom_addr,
    input  logic [IW-1:0]        rom_data,
    output logic [IW-1:0]        instr,
    output logic [mcodebits-1:0] opcode,
    output logic                 instr_valid,
    output logic [PW-1:0]        pc,
    output logic                 Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    // All-ones machine code stops the program.
    localparam logic [IW-1:0] HALT_CODE = '1;

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [IW-1:0] cur_instr;
    logic          is_halt;
    logic          br_taken;

    // The ROM address is issued during FETCH and its registered output is
    // readable during EXEC, so EXEC shows rom_data directly; instr_q keeps
    // that word afterwards so the decoder input holds its last value.
    always_comb begin
        cur_instr = (state_q == EXEC) ? rom_data : instr_q;
        is_halt   = (cur_instr == HALT_CODE);
        br_taken  = Branch && Taken;
    end

    // State register and datapath flops, synchronous active-high reset.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, exactly like the hardware.
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic: Start only matters in IDLE/HALT, halt beats branch.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (Start) state_d = FETCH;
            FETCH: state_d = EXEC;
            EXEC:  state_d = is_halt ? HALT : FETCH;
            HALT:  if (Start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: PC restart / branch / increment, instr capture.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (Start) pc_d = '0;
            end
            EXEC: begin
                instr_d = rom_data;
                if (!is_halt) begin
                    if (br_taken) pc_d = BrTarget;
                    else          pc_d = pc_q + PW'(1);  // wraps at 2^PW
                end
            end
            default: begin
                pc_d    = pc_q;
                instr_d = instr_q;
            end
        endcase
    end

    // Outputs decoded from the current state and registers.
    always_comb begin
        rom_addr    = pc_q;
        pc          = pc_q;
        instr       = cur_instr;
        opcode      = cur_instr[IW-1 -: mcodebits];
        instr_valid = (state_q == EXEC);
        Done        = (state_q == HALT);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a synchronous ROM model.
module tb_instr_fetch;

    localparam int PW = 10;
    localparam int IW = 9;
    localparam int MB = 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Branch = 1'b0;
    logic          Taken = 1'b0;
    logic [PW-1:0] BrTarget = '0;
    logic [PW-1:0] rom_addr;
    logic [IW-1:0] rom_data = '0;
    logic [IW-1:0] instr;
    logic [MB-1:0] opcode;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic          Done;

    logic [IW-1:0] rom [0:(1<<PW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.PW(PW), .IW(IW), .mcodebits(MB)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Taken(Taken),
        .BrTarget(BrTarget), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge Clk) rom_data <= rom[rom_addr];

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Start = 1'b0; Branch = 1'b0; Taken = 1'b0; BrTarget = '0;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc !== 10'h000) begin n_bad++; $display("FAIL reset_pc: got %h want 000", pc); end
        n_cmp++; if (instr !== 9'h000) begin n_bad++; $display("FAIL reset_instr: got %h want 000", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
        // Stay IDLE without Start; branch inputs ignored in IDLE.
        Branch = 1'b1; Taken = 1'b1; BrTarget = 10'h005;
        step(); step(); step();
        Branch = 1'b0; Taken = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL idle_hold_valid: got %b want 0", instr_valid); end
        n_cmp++; if (rom_addr !== 10'h000) begin n_bad++; $display("FAIL idle_hold_addr: got %h want 000", rom_addr); end
    endtask

    task automatic test_sequence();
        do_reset();
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h1FF;
        Start = 1'b1; step(); Start = 1'b0;                 // cycle 1: FETCH pc 0
        n_cmp++; if (instr_valid !== 1'b0 || rom_addr !== 10'h000) begin n_bad++; $display("FAIL seq_fetch0: valid %b addr %h want 0/000", instr_valid, rom_addr); end
        step();                                             // cycle 2: EXEC
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 9'h001) begin n_bad++; $display("FAIL seq_exec0: valid %b instr %h want 1/001", instr_valid, instr); end
        step();                                             // cycle 3: FETCH pc 1
        n_cmp++; if (rom_addr !== 10'h001 || instr_valid !== 1'b0 || instr !== 9'h001) begin n_bad++; $display("FAIL seq_fetch1: addr %h valid %b instr %h want 001/0/001", rom_addr, instr_valid, instr); end
        step();                                             // cycle 4: EXEC
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 9'h002) begin n_bad++; $display("FAIL seq_exec1: valid %b instr %h want 1/002", instr_valid, instr); end
        step(); step();                                     // cycle 6: EXEC halt
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 9'h1FF || opcode !== 3'd7) begin n_bad++; $display("FAIL seq_exec2: valid %b instr %h op %0d want 1/1FF/7", instr_valid, instr, opcode); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL seq_done_early: got %b want 0", Done); end
        step();                                             // cycle 7: HALT
        n_cmp++; if (Done !== 1'b1 || pc !== 10'h002 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL seq_halt: done %b pc %h valid %b want 1/002/0", Done, pc, instr_valid); end
        step(); step();
        n_cmp++; if (Done !== 1'b1 || instr !== 9'h1FF) begin n_bad++; $display("FAIL seq_halt_hold: done %b instr %h want 1/1FF", Done, instr); end
    endtask

    // Continues from HALT left by test_sequence.
    task automatic test_halt_restart();
        Start = 1'b1; step(); Start = 1'b0;
        n_cmp++; if (Done !== 1'b0 || rom_addr !== 10'h000 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL restart_fetch: done %b addr %h valid %b want 0/000/0", Done, rom_addr, instr_valid); end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 9'h001) begin n_bad++; $display("FAIL restart_exec: valid %b instr %h want 1/001", instr_valid, instr); end
    endtask

    task automatic test_branch();
        do_reset();
        rom[0] = 9'h0A0; rom[1] = 9'h0A0; rom[5] = 9'h0A0; rom[10'h3FF] = 9'h012;
        Start = 1'b1; step(); Start = 1'b0;                 // FETCH pc 0
        Branch = 1'b1; Taken = 1'b1; BrTarget = 10'h033;    // ignored in FETCH
        step();                                             // EXEC pc 0
        n_cmp++; if (pc !== 10'h000 || opcode !== 3'd2) begin n_bad++; $display("FAIL br_ignored_fetch: pc %h op %0d want 000/2", pc, opcode); end
        Taken = 1'b0; BrTarget = 10'h020;                   // not taken
        step();
        n_cmp++; if (rom_addr !== 10'h001) begin n_bad++; $display("FAIL br_not_taken: addr %h want 001", rom_addr); end
        Branch = 1'b0;
        step();                                             // EXEC pc 1
        Branch = 1'b1; Taken = 1'b1; BrTarget = 10'h005;
        step();
        n_cmp++; if (rom_addr !== 10'h005) begin n_bad++; $display("FAIL br_taken: addr %h want 005", rom_addr); end
        Branch = 1'b0; Taken = 1'b0;
        step();                                             // EXEC pc 5
        Branch = 1'b1; Taken = 1'b1; BrTarget = 10'h3FF;
        step();
        Branch = 1'b0; Taken = 1'b0;
        n_cmp++; if (rom_addr !== 10'h3FF) begin n_bad++; $display("FAIL br_to_top: addr %h want 3FF", rom_addr); end
        step();                                             // EXEC pc 3FF
        n_cmp++; if (instr !== 9'h012) begin n_bad++; $display("FAIL wrap_exec: instr %h want 012", instr); end
        step();
        n_cmp++; if (rom_addr !== 10'h000 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_addr: addr %h valid %b want 000/0", rom_addr, instr_valid); end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 9'h0A0) begin n_bad++; $display("FAIL wrap_continue: valid %b instr %h want 1/0A0", instr_valid, instr); end
    endtask

    task automatic test_halt_priority();
        do_reset();
        rom[0] = 9'h1FF;
        Start = 1'b1; step(); Start = 1'b0;
        step();                                             // EXEC halt code
        Branch = 1'b1; Taken = 1'b1; BrTarget = 10'h010;
        step();
        Branch = 1'b0; Taken = 1'b0;
        n_cmp++; if (Done !== 1'b1 || pc !== 10'h000 || rom_addr !== 10'h000) begin n_bad++; $display("FAIL halt_prio: done %b pc %h addr %h want 1/000/000", Done, pc, rom_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rom[0] = 9'h055; rom[1] = 9'h066;
        Start = 1'b1; step(); Start = 1'b0;
        step(); step(); step();                             // EXEC pc 1
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 9'h066) begin n_bad++; $display("FAIL mid_pre: valid %b instr %h want 1/066", instr_valid, instr); end
        Reset = 1'b1; step(); Reset = 1'b0;
        n_cmp++; if (pc !== 10'h000 || instr !== 9'h000 || instr_valid !== 1'b0 || Done !== 1'b0) begin n_bad++; $display("FAIL mid_reset: pc %h instr %h valid %b done %b want 000/000/0/0", pc, instr, instr_valid, Done); end
        step(); step();
        n_cmp++; if (instr_valid !== 1'b0 || pc !== 10'h000) begin n_bad++; $display("FAIL mid_idle: valid %b pc %h want 0/000", instr_valid, pc); end
        Start = 1'b1; step();                               // FETCH pc 0, Start held
        step();                                             // EXEC pc 0
        n_cmp++; if (instr_valid !== 1'b1 || pc !== 10'h000) begin n_bad++; $display("FAIL start_in_fetch: valid %b pc %h want 1/000", instr_valid, pc); end
        step();                                             // Start in EXEC ignored
        Start = 1'b0;
        n_cmp++; if (pc !== 10'h001 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL start_in_exec: pc %h valid %b want 001/0", pc, instr_valid); end
        Reset = 1'b1; Start = 1'b1; step(); Reset = 1'b0; Start = 1'b0;
        step(); step();
        n_cmp++; if (instr_valid !== 1'b0 || pc !== 10'h000) begin n_bad++; $display("FAIL reset_over_start: valid %b pc %h want 0/000", instr_valid, pc); end
    endtask

    initial begin
        for (int i = 0; i < (1 << PW); i++) rom[i] = '0;
        step();
        test_reset();
        test_sequence();
        test_halt_restart();
        test_branch();
        test_halt_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
